// File: rtl/jacobi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jacobi_pkg
// Description : Shared widths, state encoding and saturation constant for the
//               Jacobi iteration convergence controller.
// Revision    : 1.0 - initial release
// ============================================================================
package jacobi_pkg;

    // Default data and iteration-counter widths
    localparam int c_DW_DEFAULT = 48;
    localparam int c_IW_DEFAULT = 16;

    // Controller state encoding
    localparam int         c_ST_W      = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RUN    = 3'd1;
    localparam logic [2:0] c_ST_DRAIN  = 3'd2;
    localparam logic [2:0] c_ST_DECIDE = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // Largest representable magnitude at the default data width
    localparam logic [c_DW_DEFAULT-1:0] c_SAT_MAX = {c_DW_DEFAULT{1'b1}};

endpackage : jacobi_pkg
`default_nettype wire

// File: rtl/jacobi_abs_delta.sv
`default_nettype none
// ============================================================================
// Module      : jacobi_abs_delta
// Description : Combinational |minuend - subtrahend| for signed DW-bit
//               operands. The difference is formed at DW+1 bits, so it never
//               wraps; magnitudes that do not fit in DW bits saturate to the
//               all-ones value.
// Revision    : 1.0 - initial release
// ============================================================================
module jacobi_abs_delta #(
    parameter int DW = 48
) (
    input  logic [DW-1:0] minuend,
    input  logic [DW-1:0] subtrahend,
    output logic [DW-1:0] magnitude
);

    logic [DW:0] w_diff;
    logic [DW:0] w_abs;

    // Sign-extended subtract, two's-complement negate, clamp to DW bits
    always_comb begin
        w_diff = {minuend[DW-1], minuend} - {subtrahend[DW-1], subtrahend};
        w_abs  = w_diff[DW] ? (~w_diff + {{DW{1'b0}}, 1'b1}) : w_diff;
        // -2^DW negates to itself, which still reads as 2^DW unsigned and
        // therefore lands in the saturating branch
        magnitude = w_abs[DW] ? {DW{1'b1}} : w_abs[DW-1:0];
    end

endmodule : jacobi_abs_delta
`default_nettype wire

// File: rtl/jacobi_converge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jacobi_converge_ctrl
// Description : Iteration-level controller behind the Jacobi integrate stage.
//               Tracks the largest |new - old| update of each pass, then at
//               the end of a pass declares convergence, declares a timeout,
//               or flips the V SRAM section and launches another pass.
// Revision    : 1.0 - initial release
// ============================================================================
module jacobi_converge_ctrl
    import jacobi_pkg::*;
#(
    parameter int DW = c_DW_DEFAULT,
    parameter int IW = c_IW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          start,
    input  logic [DW-1:0] threshold,
    input  logic [IW-1:0] max_iter,
    input  logic          new_valid,
    input  logic [DW-1:0] new_value,
    input  logic [DW-1:0] old_value,
    input  logic          iter_done,
    output logic          control_vsram_section,
    output logic          run_iter,
    output logic [IW-1:0] iter_count,
    output logic [DW-1:0] max_delta,
    output logic          converged,
    output logic          timeout,
    output logic          done
);

    logic [c_ST_W-1:0] r_state;

    // Delta pipeline stage
    logic          r_dv;
    logic [DW-1:0] r_dmag;
    logic [DW-1:0] w_mag;
    logic          w_accept;

    // Per-pass running maximum and registered outputs
    logic [DW-1:0] r_acc;
    logic          r_section;
    logic          r_run_iter;
    logic [IW-1:0] r_iter_count;
    logic [DW-1:0] r_max_delta;
    logic          r_converged;
    logic          r_timeout;
    logic          r_done;

    // Decision terms
    logic [IW:0]   w_iter_inc;
    logic [IW-1:0] w_iter_sat;
    logic          w_conv_hit;
    logic          w_limit_hit;

    jacobi_abs_delta #(
        .DW (DW)
    ) u_abs_delta (
        .minuend    (new_value),
        .subtrahend (old_value),
        .magnitude  (w_mag)
    );

    // Samples are accepted while a pass runs and during the one drain cycle
    always_comb begin
        w_accept    = new_valid && ((r_state == c_ST_RUN) || (r_state == c_ST_DRAIN));
        w_iter_inc  = {1'b0, r_iter_count} + {{IW{1'b0}}, 1'b1};
        w_iter_sat  = w_iter_inc[IW] ? r_iter_count : w_iter_inc[IW-1:0];
        w_conv_hit  = (r_acc <= threshold);
        // Unsaturated count so the limit still trips at the counter ceiling
        w_limit_hit = (max_iter != {IW{1'b0}}) && (w_iter_inc >= {1'b0, max_iter});
    end

    // Register the magnitude of each accepted sample one cycle ahead of the max
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dv   <= 1'b0;
            r_dmag <= {DW{1'b0}};
        end else if (enable) begin
            r_dv <= w_accept;
            if (w_accept) begin
                r_dmag <= w_mag;
            end
        end
    end

    // Pass sequencing, running maximum and registered result outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_acc        <= {DW{1'b0}};
            r_section    <= 1'b0;
            r_run_iter   <= 1'b0;
            r_iter_count <= {IW{1'b0}};
            r_max_delta  <= {DW{1'b0}};
            r_converged  <= 1'b0;
            r_timeout    <= 1'b0;
            r_done       <= 1'b0;
        end else if (enable) begin
            // Fold in the pipelined sample; state actions below may clear it
            if (r_dv && (r_dmag > r_acc)) begin
                r_acc <= r_dmag;
            end

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_iter_count <= {IW{1'b0}};
                        r_acc        <= {DW{1'b0}};
                        r_section    <= 1'b0;
                        r_converged  <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_done       <= 1'b0;
                        r_run_iter   <= 1'b1;
                        r_state      <= c_ST_RUN;
                    end
                end

                c_ST_RUN: begin
                    if (iter_done) begin
                        r_run_iter <= 1'b0;
                        r_state    <= c_ST_DRAIN;
                    end
                end

                c_ST_DRAIN: begin
                    r_state <= c_ST_DECIDE;
                end

                c_ST_DECIDE: begin
                    r_max_delta  <= r_acc;
                    r_iter_count <= w_iter_sat;
                    if (w_conv_hit) begin
                        // Convergence takes priority over the iteration limit
                        r_converged <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end else if (w_limit_hit) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_section  <= ~r_section;
                        r_acc      <= {DW{1'b0}};
                        r_run_iter <= 1'b1;
                        r_state    <= c_ST_RUN;
                    end
                end

                default: begin
                    r_run_iter <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign control_vsram_section = r_section;
    assign run_iter              = r_run_iter;
    assign iter_count            = r_iter_count;
    assign max_delta             = r_max_delta;
    assign converged             = r_converged;
    assign timeout               = r_timeout;
    assign done                  = r_done;

endmodule : jacobi_converge_ctrl
`default_nettype wire

// File: tb/tb_jacobi_converge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jacobi_converge_ctrl
// Description : Directed plus randomized bench for jacobi_converge_ctrl with a
//               pass-level reference model (max |delta| per pass, decision).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jacobi_converge_ctrl;

    localparam int DW = 48;
    localparam int IW = 16;
    localparam longint c_SAT = 64'h0000_FFFF_FFFF_FFFF;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic [IW-1:0] max_iter = '0;
    logic          new_valid = 1'b0;
    logic [DW-1:0] new_value = '0;
    logic [DW-1:0] old_value = '0;
    logic          iter_done = 1'b0;
    logic          control_vsram_section;
    logic          run_iter;
    logic [IW-1:0] iter_count;
    logic [DW-1:0] max_delta;
    logic          converged;
    logic          timeout;
    logic          done;

    jacobi_converge_ctrl #(
        .DW (DW),
        .IW (IW)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .start                 (start),
        .threshold             (threshold),
        .max_iter              (max_iter),
        .new_valid             (new_valid),
        .new_value             (new_value),
        .old_value             (old_value),
        .iter_done             (iter_done),
        .control_vsram_section (control_vsram_section),
        .run_iter              (run_iter),
        .iter_count            (iter_count),
        .max_delta             (max_delta),
        .converged             (converged),
        .timeout               (timeout),
        .done                  (done)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the observable solve state
    longint        m_th;
    int            m_mi;
    int            m_iter;
    bit            m_sec, m_conv, m_to, m_done, m_run;
    logic [DW-1:0] m_maxd;

    // Samples for the next pass
    logic [DW-1:0] q_new[$];
    logic [DW-1:0] q_old[$];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".run_iter"},   64'(run_iter),              64'(m_run));
        check({tag, ".section"},    64'(control_vsram_section), 64'(m_sec));
        check({tag, ".iter_count"}, 64'(iter_count),            64'(m_iter));
        check({tag, ".max_delta"},  64'(max_delta),             64'(m_maxd));
        check({tag, ".converged"},  64'(converged),             64'(m_conv));
        check({tag, ".timeout"},    64'(timeout),               64'(m_to));
        check({tag, ".done"},       64'(done),                  64'(m_done));
    endtask

    // |new - old| from plain signed arithmetic, clamped to the DW-bit range
    function automatic longint ref_mag(input logic [DW-1:0] nv, input logic [DW-1:0] ov);
        longint a, b, d;
        a = {{16{nv[DW-1]}}, nv};
        b = {{16{ov[DW-1]}}, ov};
        d = a - b;
        if (d < 0) d = -d;
        if (d > c_SAT) d = c_SAT;
        return d;
    endfunction

    task automatic model_reset();
        m_iter = 0; m_sec = 0; m_conv = 0; m_to = 0; m_done = 0; m_run = 0;
        m_maxd = '0;
    endtask

    // Queue one sample whose difference is d, on a random baseline
    task automatic add_delta(input longint d);
        longint o, n;
        o = {$urandom(), $urandom()};
        o = o >>> 24;
        n = o + d;
        q_old.push_back(o[DW-1:0]);
        q_new.push_back(n[DW-1:0]);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_reset();
        check_all(tag);
    endtask

    task automatic do_start(input logic [DW-1:0] th, input logic [IW-1:0] mi);
        threshold = th;
        max_iter  = mi;
        start     = 1'b1;
        step();
        start     = 1'b0;
        m_th = {16'h0, th};
        m_mi = int'(mi);
        m_iter = 0; m_sec = 0; m_conv = 0; m_to = 0; m_done = 0; m_run = 1;
        check_all("start");
    endtask

    // Feed the queued samples as one pass, end it, and check the decision.
    // stall_at: sample index before which enable drops for 5 cycles (-1 none)
    task automatic run_pass(input bit simul, input int stall_at, input bit start_in_run);
        longint acc, m;
        int n;
        acc = 0;
        n = q_new.size();
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                enable = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    new_valid = ((k % 2) == 0);
                    new_value = {$urandom(), $urandom()};
                    old_value = {$urandom(), $urandom()};
                    iter_done = (k == 3);
                    start     = (k == 1);
                    step();
                end
                new_valid = 1'b0; iter_done = 1'b0; start = 1'b0;
                enable = 1'b1;
                check("stall.run_iter", 64'(run_iter), 64'd1);
                check("stall.done", 64'(done), 64'd0);
            end
            new_valid = 1'b1;
            new_value = q_new[i];
            old_value = q_old[i];
            if (simul && (i == n - 1)) iter_done = 1'b1;
            if (start_in_run && (i == 0)) start = 1'b1;
            step();
            new_valid = 1'b0; iter_done = 1'b0; start = 1'b0;
            m = ref_mag(q_new[i], q_old[i]);
            if (m > acc) acc = m;
            if (!(simul && (i == n - 1)) && ($urandom_range(0, 2) == 0)) step();
        end
        if (!simul) begin
            iter_done = 1'b1;
            step();
            iter_done = 1'b0;
        end
        check("drain.run_iter", 64'(run_iter), 64'd0);
        step();
        check("decide.run_iter", 64'(run_iter), 64'd0);
        step();
        m_iter++;
        m_maxd = acc[DW-1:0];
        if (acc <= m_th) begin
            m_conv = 1; m_done = 1;
        end else if ((m_mi != 0) && (m_iter >= m_mi)) begin
            m_to = 1; m_done = 1;
        end else begin
            m_sec = ~m_sec;
        end
        m_run = !m_done;
        check_all("pass");
        q_new.delete();
        q_old.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        m_th = 0; m_mi = 0;
        enable = 1'b1;
        step();
        step();
        check_all("reset");
        reset = 1'b1;

        // start while disabled is ignored
        enable = 1'b0; start = 1'b1;
        step();
        start = 1'b0; enable = 1'b1;
        check_all("en_low_start");

        // Basic converge, tie on threshold in pass 2
        do_start(48'h10, 16'd8);
        add_delta(64'h40); add_delta(-128); add_delta(5);
        run_pass(1'b0, -1, 1'b0);
        add_delta(3); add_delta(-16);
        run_pass(1'b0, -1, 1'b0);

        // Pulses in DONE change nothing
        iter_done = 1'b1; new_valid = 1'b1; new_value = {$urandom(), $urandom()};
        step();
        iter_done = 1'b0; new_valid = 1'b0;
        check_all("done_hold");

        // Timeout after 3 passes
        do_start(48'h0, 16'd3);
        for (int p = 0; p < 3; p++) begin
            add_delta(1);
            run_pass(1'b0, -1, 1'b0);
        end

        // Saturation of the largest possible difference, both directions
        do_start(48'h0, 16'd1);
        q_new.push_back(48'h7FFF_FFFF_FFFF); q_old.push_back(48'h8000_0000_0000);
        q_new.push_back(48'h8000_0000_0000); q_old.push_back(48'h7FFF_FFFF_FFFF);
        run_pass(1'b0, -1, 1'b0);

        // Sample coincident with iter_done; start during RUN ignored
        do_start(48'h20, 16'd4);
        add_delta(64'h10); add_delta(64'h99);
        run_pass(1'b1, -1, 1'b1);
        add_delta(-2);
        run_pass(1'b1, -1, 1'b0);

        // Enable stall mid-pass
        do_start(48'h30, 16'd3);
        add_delta(64'h50); add_delta(-32); add_delta(64'h31);
        run_pass(1'b0, 1, 1'b0);
        add_delta(64'h12); add_delta(64'h2F);
        run_pass(1'b0, 1, 1'b0);

        // Both conditions hold: converged wins
        do_start(48'h10, 16'd1);
        add_delta(4);
        run_pass(1'b0, -1, 1'b0);

        // Unlimited iterations
        do_start(48'h8, 16'd0);
        add_delta(64'h100); run_pass(1'b0, -1, 1'b0);
        add_delta(-9);      run_pass(1'b0, -1, 1'b0);
        add_delta(8);       run_pass(1'b0, -1, 1'b0);

        // Reset during DRAIN, then a clean solve
        do_start(48'h0, 16'd5);
        add_delta(64'h77);
        new_valid = 1'b1; new_value = q_new[0]; old_value = q_old[0];
        step();
        new_valid = 1'b0; iter_done = 1'b1;
        step();
        iter_done = 1'b0;
        q_new.delete(); q_old.delete();
        do_reset("rst_drain");
        do_start(48'h1000, 16'd4);
        add_delta(64'h20);
        run_pass(1'b0, -1, 1'b0);

        // Randomized solves
        for (int s = 0; s < 6; s++) begin
            do_start(48'($urandom_range(0, 32'h200)), 16'($urandom_range(1, 4)));
            while (!m_done) begin
                int nd;
                nd = $urandom_range(1, 4);
                for (int j = 0; j < nd; j++) begin
                    longint d;
                    d = longint'($urandom_range(0, 32'h300));
                    if ($urandom_range(0, 1) == 1) d = -d;
                    add_delta(d);
                end
                run_pass(1'($urandom_range(0, 1)), -1, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_jacobi_converge_ctrl
`default_nettype wire

// File: doc/jacobi_converge_ctrl.md
Name: jacobi_converge_ctrl

Overview:
- Iteration-level controller directly downstream of the Jacobi integrate stage.
- Consumes each new V value from the divider (`dividor_done` strobe) together with the previous-iteration V value, and tracks the maximum absolute update.
- At `iter_done` it decides among three outcomes: converged, iteration limit reached, or start another pass.
- Drives `control_vsram_section` (V SRAM ping-pong select) and `run_iter` (enable to integrate).

Parameters:
- DW, 48, data width of V values, threshold and delta.
- IW, 16, iteration counter width.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  global enable; when low all state and outputs hold
- start  in  1  single-cycle pulse, begins a solve
- threshold  in  DW  unsigned convergence bound on max |delta|
- max_iter  in  IW  iteration limit; 0 = unlimited
- new_valid  in  1  strobe, new_value/old_value valid (tied to dividor_done)
- new_value  in  DW  signed two's-complement V value just computed
- old_value  in  DW  signed V value of same row, previous iteration
- iter_done  in  1  pulse from integrate: last row of current pass finished
- control_vsram_section  out  1  V SRAM section select (write half)
- run_iter  out  1  enable for integrate pass
- iter_count  out  IW  completed iterations
- max_delta  out  DW  max |delta| of last completed iteration
- converged  out  1  solve ended by threshold
- timeout  out  1  solve ended by max_iter
- done  out  1  solve finished (converged or timeout)

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE; all outputs 0; accumulator acc=0; pipeline valid=0.
  - Reset mid-solve aborts immediately, with no done pulse.
- enable==0: nothing updates, including the pipeline. Inputs sampled in that cycle are ignored.
- Delta pipeline (1 stage):
  - On new_valid in RUN: d = new_value − old_value, computed at DW+1 bits signed.
  - Register |d| saturated to 2^DW−1 (the case d = −2^DW saturates). dv<=1.
  - Next cycle: if dv, acc <= max(acc, |d|_reg).
  - new_valid outside RUN or DRAIN is ignored.
- States:
  - IDLE: outputs hold (post-reset all 0).
    - On start: iter_count=0, acc=0, control_vsram_section=0, converged=timeout=done=0, run_iter=1 → RUN.
  - RUN: run_iter=1; accept new_valid.
    - On iter_done: run_iter<=0 → DRAIN.
    - A new_valid in the same cycle as iter_done is included.
  - DRAIN (1 cycle): lets the pipeline's final sample update acc.
    - new_valid here is still accepted and goes through the pipeline, but is not guaranteed to be included. The bench must not drive it.
    - → DECIDE.
  - DECIDE (1 cycle): max_delta<=acc; iter_count<=iter_count+1 (saturating at 2^IW−1).
    - If acc <= threshold: converged<=1, done<=1 → DONE.
    - Else if max_iter!=0 and iter_count+1 >= max_iter: timeout<=1, done<=1 → DONE.
    - Else: control_vsram_section toggles, acc<=0, run_iter<=1 → RUN.
  - DONE: done, converged/timeout, max_delta, iter_count held.
    - start → same action as from IDLE (restart).
- start in RUN/DRAIN/DECIDE is ignored.
- iter_done outside RUN is ignored.
- Latency:
  - iter_done → decision registered 2 cycles later; done or run_iter rises at the end of DECIDE.
  - run_iter low for exactly 2 cycles between passes.
- Tie on threshold (acc == threshold) counts as converged.
- If both the converged and timeout conditions hold, converged wins and timeout stays 0.

Decomposition:
- Shared package jacobi_pkg:
  - DW/IW defaults.
  - State encoding constants: IDLE, RUN, DRAIN, DECIDE, DONE.
  - Saturated-max constant.
- One sub-module: jacobi_abs_delta. Combinational signed subtract, absolute value and saturation. Reused wherever a residual magnitude is needed.

Test Plan:
- Basic converge: threshold=0x10, max_iter=8, start; pass 1 deltas {0x40,−0x80,0x5}, iter_done → max_delta=0x80, section=1, run_iter back 1 after 2 low cycles. Pass 2 deltas {0x3,−0x10} → converged=1, done=1, iter_count=2, max_delta=0x10.
- Timeout: threshold=0, max_iter=3, every pass a delta of 1 → timeout=1, converged=0, iter_count=3, section toggled twice then held at 0.
- Saturation: new_value=0x7FFF_FFFF_FFFF, old_value=0x8000_0000_0000 → max_delta=0xFFFF_FFFF_FFFF.
- Simultaneous: new_valid with delta 0x99 in the same cycle as iter_done → max_delta=0x99. Also start asserted during RUN is ignored.
- enable low for 5 cycles mid-RUN while new_valid toggles → acc unchanged, state held. Resume and finish, with results matching the run without the stall.
- Reset low during DRAIN → next cycle all outputs 0, state IDLE. A following start runs normally with iter_count starting from 0.
